cgra_config_loader: RTL and testbench

- Sequencer that loads the serial configuration chain of the CGRA processing-element array.
- Per PE the chain holds 46 bits: FuncConfig 4, MuxA 3, MuxB 3, MuxBypass 3, MuxOut 1, const 32.
- Accepts 32-bit configuration words over a valid/ready handshake and serialises them LSB-first onto the chain input.
- Controls the chain's shift enable and chain reset, counts exactly CHAIN_BITS shifts, then reports done. Sits between the host/RoCC config interface and the PE array's ConfigIn.

---
 rtl/cgra_cfg_pkg.sv | 29 ++
 rtl/cfg_word_serializer.sv | 44 ++++
 rtl/cgra_config_loader.sv | 114 +++++++++++
 tb/tb_cgra_config_loader.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cgra_cfg_pkg.sv
// Shared definitions for the CGRA configuration-chain loader: PE field widths,
// array size, FSM state encoding and the word-count helper.
package cgra_cfg_pkg;

  localparam int FUNC_CFG_W   = 4;
  localparam int MUX_A_W      = 3;
  localparam int MUX_B_W      = 3;
  localparam int MUX_BYPASS_W = 3;
  localparam int MUX_OUT_W    = 1;
  localparam int CONST_W      = 32;
  localparam int PE_CFG_BITS  = FUNC_CFG_W + MUX_A_W + MUX_B_W + MUX_BYPASS_W
                              + MUX_OUT_W + CONST_W;
  localparam int NUM_PE       = 12;
  localparam int WORD_W       = 32;
  localparam int WBITS_W      = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } cfg_state_e;

  // Number of 32-bit host words needed to cover a chain of the given length.
  function automatic int WORDS_NEEDED(input int chain_bits);
    return (chain_bits + WORD_W - 1) / WORD_W;
  endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// One-word buffer that accepts 32-bit config words and shifts them out LSB-first.
// Refills on the same edge that drains the last bit so a held-valid host sees no bubble.
module cfg_word_serializer
  import cgra_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              active,
  input  logic              can_accept,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              accept,
  output logic              shift_en,
  output logic              config_out
);

  logic [WORD_W-1:0]  sreg;
  logic [WBITS_W-1:0] wbits;

  assign shift_en   = active && (wbits != '0);
  assign word_ready = active && can_accept &&
                      ((wbits == '0) || ((wbits == WBITS_W'(1)) && shift_en));
  assign accept     = word_valid && word_ready;
  assign config_out = sreg[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg  <= '0;
      wbits <= '0;
    end else if (flush) begin
      sreg  <= '0;
      wbits <= '0;
    end else if (accept) begin
      sreg  <= word_in;
      wbits <= WBITS_W'(WORD_W);
    end else if (shift_en) begin
      sreg  <= sreg >> 1;
      wbits <= wbits - 1'b1;
    end
  end

endmodule

// File: rtl/cgra_config_loader.sv
// Sequencer for the PE-array serial configuration chain: clears the chain, shifts
// exactly CHAIN_BITS bits from host words, then pulses done.
module cgra_config_loader
  import cgra_cfg_pkg::*;
#(
  parameter int CHAIN_BITS   = PE_CFG_BITS * NUM_PE,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                            Config_Clock,
  input  logic                            Config_Reset,
  input  logic                            start,
  input  logic                            abort,
  input  logic [WORD_W-1:0]               word_in,
  input  logic                            word_valid,
  output logic                            word_ready,
  output logic                            ConfigOut,
  output logic                            cfg_shift_en,
  output logic                            cfg_chain_reset,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(CHAIN_BITS+1)-1:0] bit_count
);

  localparam int BCW   = $clog2(CHAIN_BITS + 1);
  localparam int WORDS = WORDS_NEEDED(CHAIN_BITS);
  localparam int WAW   = $clog2(WORDS + 1);
  localparam int CCW   = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  cfg_state_e     state, state_nxt;
  logic [CCW-1:0] clr_cnt;
  logic [WAW-1:0] words_accepted;
  logic           load_active;
  logic           can_accept;
  logic           accept;
  logic           last_shift;
  logic           flush;
  logic           clr_last;
  logic           begin_load;

  assign load_active = (state == ST_LOAD);
  assign can_accept  = (words_accepted < WAW'(WORDS));
  assign clr_last    = (clr_cnt == CCW'(CLEAR_CYCLES - 1));
  assign last_shift  = cfg_shift_en && (bit_count == BCW'(CHAIN_BITS - 1));
  // Bits left in the final word past the chain end are dropped here.
  assign flush       = abort || last_shift;
  assign begin_load  = (state == ST_IDLE) && start && !abort;

  cfg_word_serializer u_ser (
    .clk        (Config_Clock),
    .rst_n      (Config_Reset),
    .flush      (flush),
    .active     (load_active),
    .can_accept (can_accept),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .accept     (accept),
    .shift_en   (cfg_shift_en),
    .config_out (ConfigOut)
  );

  always_ff @(posedge Config_Clock or negedge Config_Reset) begin
    if (!Config_Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    busy            = 1'b0;
    done            = 1'b0;
    cfg_chain_reset = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy            = 1'b1;
        cfg_chain_reset = 1'b1;
        if (clr_last) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (last_shift) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  // Counters clear only when a load actually begins so bit_count holds after DONE.
  always_ff @(posedge Config_Clock or negedge Config_Reset) begin
    if (!Config_Reset) begin
      clr_cnt        <= '0;
      words_accepted <= '0;
      bit_count      <= '0;
    end else if (begin_load) begin
      clr_cnt        <= '0;
      words_accepted <= '0;
      bit_count      <= '0;
    end else begin
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (accept)            words_accepted <= words_accepted + 1'b1;
      if (cfg_shift_en)      bit_count <= bit_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cgra_config_loader.sv
// Directed bench for cgra_config_loader: a 46-bit chain instance and a default
// 552-bit instance, with a bit-stream scoreboard filled from the offered words.
module tb_cgra_config_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        s_start = 1'b0, s_abort = 1'b0, s_valid = 1'b0;
  logic [31:0] s_word = '0;
  logic        s_ready, s_out, s_sen, s_crst, s_busy, s_done;
  logic [5:0]  s_bc;

  logic        b_start = 1'b0, b_abort = 1'b0, b_valid = 1'b0;
  logic [31:0] b_word = '0;
  logic        b_ready, b_out, b_sen, b_crst, b_busy, b_done;
  logic [9:0]  b_bc;

  always #5 clk = ~clk;

  cgra_config_loader #(.CHAIN_BITS(46), .CLEAR_CYCLES(2)) dut_s (
    .Config_Clock(clk), .Config_Reset(rst_n), .start(s_start), .abort(s_abort),
    .word_in(s_word), .word_valid(s_valid), .word_ready(s_ready), .ConfigOut(s_out),
    .cfg_shift_en(s_sen), .cfg_chain_reset(s_crst), .busy(s_busy), .done(s_done),
    .bit_count(s_bc)
  );

  cgra_config_loader dut_b (
    .Config_Clock(clk), .Config_Reset(rst_n), .start(b_start), .abort(b_abort),
    .word_in(b_word), .word_valid(b_valid), .word_ready(b_ready), .ConfigOut(b_out),
    .cfg_shift_en(b_sen), .cfg_chain_reset(b_crst), .busy(b_busy), .done(b_done),
    .bit_count(b_bc)
  );

  int checks = 0;
  int errors = 0;

  logic        exp_q[$];
  logic [31:0] sw[2];
  logic [31:0] bw[19];
  int hs, sh, first_sh, last_sh, done_cyc, done_n, acc0_cyc, aborted_c, prev_bc;
  logic [7:0] crst_mask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 plain, 1 valid gap, 2 abort at bit_count 20, 3 second start, 4 reset mid-load
  task automatic run_small(input int mode, input int max_c);
    hs = 0; sh = 0; first_sh = -1; last_sh = -1; done_cyc = -1; done_n = 0;
    acc0_cyc = -1; aborted_c = -1; prev_bc = 0; crst_mask = '0;
    exp_q.delete();
    for (int i = 0; i < 46; i++) exp_q.push_back(sw[i / 32][i % 32]);
    for (int c = 0; c < max_c; c++) begin
      @(negedge clk);
      if (s_sen) begin
        sh++;
        if (first_sh < 0) first_sh = c;
        last_sh = c;
        if (exp_q.size() > 0) chk("s_bit", s_out, exp_q.pop_front());
        else chk("s_extra_shift", 1, 0);
      end
      if (s_done) begin done_n++; done_cyc = c; end
      if (c < 8) crst_mask[c] = s_crst;
      if (hs >= 2) chk("s_ready_after_last", s_ready, 0);
      if (mode == 3 && c >= 2) chk("s_bc_monotonic", 64'(s_bc >= 6'(prev_bc)), 1);
      prev_bc = s_bc;
      if (mode == 2 && aborted_c >= 0 && c == aborted_c + 1) begin
        chk("abort_busy", s_busy, 0);
        chk("abort_shift_en", s_sen, 0);
      end
      if (mode == 4 && c == 22) begin
        chk("post_reset_busy", s_busy, 0);
        chk("post_reset_shift_en", s_sen, 0);
      end
      s_start = (c == 0) || (mode == 3 && c == 20);
      s_abort = 1'b0;
      if (mode == 2 && s_bc == 6'd20 && aborted_c < 0) begin
        s_abort = 1'b1;
        aborted_c = c;
      end
      s_valid = !(mode == 1 && c >= 35 && c < 40);
      s_word  = sw[(hs < 2) ? hs : 1];
      if (s_valid && s_ready) begin
        if (hs == 0) acc0_cyc = c;
        hs++;
      end
      if (mode == 4 && c == 20) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", s_busy, 0);
        chk("async_rst_shift_en", s_sen, 0);
        chk("async_rst_chain_reset", s_crst, 0);
        chk("async_rst_done", s_done, 0);
        chk("async_rst_ready", s_ready, 0);
        chk("async_rst_configout", s_out, 0);
        chk("async_rst_bit_count", s_bc, 0);
      end
      if (mode == 4 && c == 21) rst_n = 1'b1;
    end
    s_start = 1'b0; s_abort = 1'b0; s_valid = 1'b0;
  endtask

  task automatic check_full_small(input string tag, input int exp_done);
    chk({tag, "_done_cycle"}, done_cyc, exp_done);
    chk({tag, "_done_count"}, done_n, 1);
    chk({tag, "_shift_count"}, sh, 46);
    chk({tag, "_handshakes"}, hs, 2);
    chk({tag, "_bit_count"}, s_bc, 46);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    sw[0] = 32'h8000_0001;
    sw[1] = 32'h0000_2ABC;
    for (int i = 0; i < 19; i++) bw[i] = $urandom;

    repeat (2) @(negedge clk);
    chk("reset_busy", s_busy, 0);
    chk("reset_done", s_done, 0);
    chk("reset_chain_reset", s_crst, 0);
    chk("reset_shift_en", s_sen, 0);
    chk("reset_ready", s_ready, 0);
    chk("reset_configout", s_out, 0);
    chk("reset_bit_count", s_bc, 0);
    chk("reset_big_busy", b_busy, 0);
    rst_n = 1'b1;

    // Simultaneous start and abort while idle: stays idle.
    @(negedge clk);
    s_start = 1'b1; s_abort = 1'b1;
    @(negedge clk);
    s_start = 1'b0; s_abort = 1'b0;
    chk("start_abort_busy", s_busy, 0);
    chk("start_abort_chain_reset", s_crst, 0);

    // Basic load with valid held high.
    run_small(0, 60);
    check_full_small("basic", 50);
    chk("basic_chain_reset_cycles", crst_mask, 8'b0000_0110);
    chk("basic_first_accept", acc0_cyc, 3);
    chk("basic_first_shift", first_sh, 4);
    chk("basic_last_shift", last_sh, 49);

    // Valid dropped for 5 cycles once word0 is draining.
    run_small(1, 65);
    check_full_small("gap", 55);
    chk("gap_first_shift", first_sh, 4);
    chk("gap_last_shift", last_sh, 54);

    // Abort at bit_count 20, then a clean reload.
    run_small(2, 40);
    chk("abort_cycle", aborted_c, 24);
    chk("abort_shift_count", sh, 21);
    chk("abort_done_count", done_n, 0);
    run_small(0, 60);
    check_full_small("after_abort", 50);

    // Second start during LOAD is ignored.
    run_small(3, 60);
    check_full_small("restart", 50);

    // Reset pulse mid-load, then a clean reload.
    run_small(4, 30);
    chk("reset_mid_done_count", done_n, 0);
    run_small(0, 60);
    check_full_small("after_reset", 50);

    // Default 552-bit chain with 19 words offered.
    hs = 0; sh = 0; done_cyc = -1; done_n = 0;
    exp_q.delete();
    for (int i = 0; i < 552; i++) exp_q.push_back(bw[i / 32][i % 32]);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (b_sen) begin
        sh++;
        if (exp_q.size() > 0) chk("b_bit", b_out, exp_q.pop_front());
        else chk("b_extra_shift", 1, 0);
      end
      if (b_done) begin done_n++; done_cyc = c; end
      if (hs >= 18) chk("b_ready_after_last", b_ready, 0);
      b_start = (c == 0);
      b_valid = 1'b1;
      b_word  = bw[(hs < 19) ? hs : 18];
      if (b_valid && b_ready) hs++;
    end
    b_start = 1'b0; b_valid = 1'b0;
    chk("big_handshakes", hs, 18);
    chk("big_shift_count", sh, 552);
    chk("big_done_count", done_n, 1);
    chk("big_done_cycle", done_cyc, 556);
    chk("big_bit_count", b_bc, 552);
    chk("big_queue_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
